viterbi_acs_ctrl: RTL
=====================

Name: viterbi_acs_ctrl

Overview:
- Frame-level sequencer for the Viterbi decoder datapath.
- Accepts received symbols through a valid/ready handshake and pipelines enables to the branch-metric unit (BMU) and the add-compare-select unit (ACS).
- Tracks the survivor-memory write pointer, then launches traceback once the frame is fully processed and reports completion.
- Sits between the input symbol buffer and the BMU/ACS/traceback blocks.

Parameters:
- SURV_ADDR_W, 8, survivor-memory address width; maximum frame = 2^SURV_ADDR_W symbols.
- LEN_W, 16, width of the frame-length input.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- i_start  input  1  one-cycle pulse that starts a frame; ignored unless the block is in IDLE.
- i_frame_len  input  LEN_W  number of symbols in the frame; sampled when i_start is accepted.
- i_sym_valid  input  1  upstream symbol valid.
- o_sym_ready  output  1  the controller can take a symbol this cycle.
- o_en_bm  output  1  BMU enable, one cycle per accepted symbol.
- o_en_acs  output  1  ACS enable, one cycle per processed symbol.
- o_acs_clr  output  1  one-cycle clear of the ACS path metrics at frame start.
- o_wr_addr  output  SURV_ADDR_W  survivor-memory write address; qualified by o_en_acs.
- o_tb_start  output  1  one-cycle traceback launch pulse.
- o_tb_addr  output  SURV_ADDR_W  traceback start address (last written address); held stable from o_tb_start until i_tb_done.
- i_tb_done  input  1  traceback complete pulse.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle frame-complete pulse.
- o_err  output  1  one-cycle pulse when a frame length is illegal.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset asserted mid-frame aborts the frame immediately, with no o_done and no o_err.
- States are IDLE, INIT, RUN, DRAIN, TB, DONE. All outputs are registered.
- IDLE:
  - i_start with i_frame_len == 0 -> DONE, with no ACS activity.
  - i_start with i_frame_len > 2^SURV_ADDR_W -> o_err pulses next cycle, FSM stays in IDLE.
  - i_start with a legal length -> INIT, and the length is latched.
- INIT:
  - o_acs_clr = 1 for exactly one cycle.
  - Symbol count and write pointer are set to 0.
  - Next state is RUN.
- RUN:
  - o_sym_ready = 1 while accepted count < latched length.
  - A symbol is accepted when i_sym_valid && o_sym_ready.
  - Pipeline: acceptance at cycle t -> o_en_bm = 1 at t+1 -> o_en_acs = 1 at t+2, with o_wr_addr = index of that symbol.
  - Back-to-back acceptance gives one symbol per cycle, no bubbles.
  - Gaps in i_sym_valid propagate as gaps in both enables.
  - The cycle after the last symbol is accepted, o_sym_ready = 0 and FSM -> DRAIN.
- DRAIN:
  - Waits until the final o_en_acs has been issued (two cycles after the last acceptance).
  - Then o_tb_addr = latched length - 1 and FSM -> TB.
- TB:
  - o_tb_start pulses on the first cycle in TB.
  - The FSM then waits indefinitely for i_tb_done.
  - i_tb_done in the same cycle as o_tb_start is legal and is accepted.
  - i_tb_done outside TB is ignored.
  - On i_tb_done, FSM -> DONE.
- DONE: o_done = 1 for one cycle, then IDLE.
- A new i_start is accepted in the cycle after o_done.
- Write pointer: increments per o_en_acs. A frame of exactly 2^SURV_ADDR_W symbols ends at the all-ones address and must not wrap inside the frame.
- Symbol counter width is LEN_W+1, so a maximum legal length cannot overflow.
- i_sym_valid outside RUN has no effect and gives no ready.
- o_en_bm and o_en_acs are never high outside RUN or DRAIN.

Decomposition:
- Shared package viterbi_pkg holds:
  - the FSM state enum type;
  - constant SURV_DEPTH = 2^SURV_ADDR_W;
  - shared enable/handshake widths, alongside the existing MAX_TRANSITION_NUM.
- One natural sub-module, viterbi_en_pipe: a 2-stage shift register that turns the accept strobe into o_en_bm and o_en_acs and carries the write index alongside.

Test Plan:
- Frame of 4 symbols, valid held high -> o_acs_clr once; o_en_bm high 4 consecutive cycles; o_en_acs high 4 cycles, one cycle later, with o_wr_addr 0,1,2,3. Then o_tb_start with o_tb_addr = 3; i_tb_done 5 cycles later -> o_done one cycle later.
- Frame of 6 symbols, valid toggling 1,0,1,1,0,... -> enables mirror the gaps delayed by 1 and 2 cycles; exactly 6 o_en_acs pulses; ready drops after the 6th accept.
- i_frame_len = 0 -> o_done without any o_acs_clr or enables. i_frame_len = 257 with SURV_ADDR_W = 8 -> o_err pulse, o_busy stays 0.
- Frame of 256 -> last o_wr_addr = 255, o_tb_addr = 255, no wrap.
- rst asserted during RUN after 3 symbols -> all outputs 0 at once. A subsequent frame of 2 starts cleanly from o_wr_addr 0.
- i_start while busy, i_tb_done during RUN, and i_tb_done coincident with o_tb_start -> the first two are ignored; the coincident pulse completes traceback and o_done follows next cycle.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder control path.
// Pure declarations: no latency, no backpressure.
package viterbi_pkg;

  localparam int MAX_TRANSITION_NUM = 2;
  localparam int SURV_ADDR_W_DEF    = 8;
  localparam int SURV_DEPTH         = 1 << SURV_ADDR_W_DEF;
  localparam int EN_W               = 1;
  localparam int HS_W               = 1;
  localparam int EN_PIPE_STAGES     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_TB,
    ST_DONE
  } state_e;

  function automatic int surv_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/viterbi_en_pipe.sv
// Two-stage enable pipe: accept strobe -> BMU enable (+1) -> ACS enable (+2), index rides along.
// No backpressure; the index reads 0 on any stage that carries no symbol.
module viterbi_en_pipe
  import viterbi_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             en_bm_o,
  output logic             en_acs_o,
  output logic [IDX_W-1:0] idx_o
);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } stage_t;

  stage_t s1_d, s1_q, s2_q;

  always_comb begin
    s1_d.vld = acc_i;
    s1_d.idx = acc_i ? idx_i : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  assign en_bm_o  = s1_q.vld;
  assign en_acs_o = s2_q.vld;
  assign idx_o    = s2_q.idx;

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer for BMU/ACS/traceback; enables trail symbol acceptance by 1 and 2 cycles.
// Upstream is throttled by o_sym_ready only; traceback completion is awaited indefinitely.
module viterbi_acs_ctrl
  import viterbi_pkg::*;
#(
  parameter int SURV_ADDR_W = 8,
  parameter int LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [LEN_W-1:0]       i_frame_len,
  input  logic                   i_sym_valid,
  output logic                   o_sym_ready,
  output logic                   o_en_bm,
  output logic                   o_en_acs,
  output logic                   o_acs_clr,
  output logic [SURV_ADDR_W-1:0] o_wr_addr,
  output logic                   o_tb_start,
  output logic [SURV_ADDR_W-1:0] o_tb_addr,
  input  logic                   i_tb_done,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(surv_depth(SURV_ADDR_W));
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W:0]         cnt_q, cnt_d;
  logic [SURV_ADDR_W-1:0] tb_addr_q, tb_addr_d;
  logic                   ready_q, ready_d;
  logic                   clr_q, clr_d;
  logic                   tbs_q, tbs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   en_bm, en_acs;
  logic [SURV_ADDR_W-1:0] wr_addr;
  logic [LEN_W:0]         len_ext, frame_ext;

  assign len_ext   = {1'b0, len_q};
  assign frame_ext = {1'b0, i_frame_len};
  assign accept    = (state_q == ST_RUN) && i_sym_valid && ready_q;

  viterbi_en_pipe #(
    .IDX_W (SURV_ADDR_W)
  ) u_en_pipe (
    .clk      (clk),
    .rst      (rst),
    .acc_i    (accept),
    .idx_i    (cnt_q[SURV_ADDR_W-1:0]),
    .en_bm_o  (en_bm),
    .en_acs_o (en_acs),
    .idx_o    (wr_addr)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tb_addr_d = tb_addr_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_frame_len == '0) begin
            state_d = ST_DONE;
          end else if (frame_ext > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            len_d   = i_frame_len;
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == len_ext) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Stage 1 empty means the final ACS enable is on the bus now, carrying len-1.
        if (!en_bm) begin
          tb_addr_d = wr_addr;
          state_d   = ST_TB;
        end
      end
      ST_TB: begin
        if (i_tb_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_RUN) && (cnt_d < len_ext);
    clr_d   = (state_d == ST_INIT);
    tbs_d   = (state_q == ST_DRAIN) && (state_d == ST_TB);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tb_addr_q <= '0;
      ready_q   <= 1'b0;
      clr_q     <= 1'b0;
      tbs_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tb_addr_q <= tb_addr_d;
      ready_q   <= ready_d;
      clr_q     <= clr_d;
      tbs_q     <= tbs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_sym_ready = ready_q;
  assign o_en_bm     = en_bm;
  assign o_en_acs    = en_acs;
  assign o_acs_clr   = clr_q;
  assign o_wr_addr   = wr_addr;
  assign o_tb_start  = tbs_q;
  assign o_tb_addr   = tb_addr_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
